// File: rtl/aeolus_pkg.sv
// Shared definitions for the Aeolus multi-cycle CPU: opcode values and FSM states.
package aeolus_pkg;

    localparam logic [3:0] OP_LDA  = 4'd0;
    localparam logic [3:0] OP_LDB  = 4'd1;
    localparam logic [3:0] OP_LDO  = 4'd2;
    localparam logic [3:0] OP_LDSA = 4'd3;
    localparam logic [3:0] OP_LDSB = 4'd4;
    localparam logic [3:0] OP_LSH  = 4'd5;
    localparam logic [3:0] OP_RSH  = 4'd6;
    localparam logic [3:0] OP_CLR  = 4'd7;
    localparam logic [3:0] OP_SNZA = 4'd8;
    localparam logic [3:0] OP_SNZS = 4'd9;
    localparam logic [3:0] OP_ADD  = 4'd10;
    localparam logic [3:0] OP_SUB  = 4'd11;
    localparam logic [3:0] OP_AND  = 4'd12;
    localparam logic [3:0] OP_OR   = 4'd13;
    localparam logic [3:0] OP_XOR  = 4'd14;
    localparam logic [3:0] OP_INV  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_e;

endpackage

// File: rtl/aeolus_mc_cpu_if.sv
// Instruction-memory req/ack port. The CPU is the master; the memory responds.
interface aeolus_mc_cpu_if #(
    parameter int ADDR_W = 8
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [3:0]        imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/aeolus_mc_exec.sv
// Combinational datapath: next values of ACC, OF, SR and SF for one opcode.
// Registers the opcode does not touch are passed through unchanged.
module aeolus_mc_exec
    import aeolus_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8
) (
    input  logic [3:0]       opcode,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic [OUT_W-1:0] acc,
    input  logic [OUT_W-1:0] sr,
    input  logic             of,
    input  logic             sf,
    output logic [OUT_W-1:0] acc_nxt,
    output logic             of_nxt,
    output logic [OUT_W-1:0] sr_nxt,
    output logic             sf_nxt
);

    logic [OUT_W-1:0] a_ext;
    logic [OUT_W-1:0] b_ext;
    logic [OUT_W:0]   sum_acc_a;
    logic [OUT_W:0]   sum_acc_sr;
    logic [OUT_W:0]   sum_ab;
    logic [OUT_W:0]   diff_ab;

    // Arithmetic is one bit wider than ACC so the top bit is carry (or borrow for SUB).
    assign a_ext      = OUT_W'(a);
    assign b_ext      = OUT_W'(b);
    assign sum_acc_a  = {1'b0, acc} + {1'b0, a_ext};
    assign sum_acc_sr = {1'b0, acc} + {1'b0, sr};
    assign sum_ab     = {1'b0, a_ext} + {1'b0, b_ext};
    assign diff_ab    = {1'b0, a_ext} - {1'b0, b_ext};

    // Select the result for the current opcode; default is hold.
    always_comb begin
        acc_nxt = acc;
        of_nxt  = of;
        sr_nxt  = sr;
        sf_nxt  = sf;
        case (opcode)
            OP_LDSA: sr_nxt = a_ext;
            OP_LDSB: sr_nxt = b_ext;
            OP_LSH: begin
                sr_nxt = sr << 1;
                sf_nxt = sr[OUT_W-1];
            end
            OP_RSH: begin
                sr_nxt = sr >> 1;
                sf_nxt = sr[0];
            end
            OP_CLR: begin
                acc_nxt = '0;
                of_nxt  = 1'b0;
            end
            OP_SNZA: begin
                if (sf) begin
                    acc_nxt = sum_acc_a[OUT_W-1:0];
                    of_nxt  = sum_acc_a[OUT_W];
                end
            end
            OP_SNZS: begin
                if (sf) begin
                    acc_nxt = sum_acc_sr[OUT_W-1:0];
                    of_nxt  = sum_acc_sr[OUT_W];
                end
            end
            OP_ADD: begin
                acc_nxt = sum_ab[OUT_W-1:0];
                of_nxt  = sum_ab[OUT_W];
            end
            OP_SUB: begin
                acc_nxt = diff_ab[OUT_W-1:0];
                of_nxt  = diff_ab[OUT_W];
            end
            OP_AND: begin
                acc_nxt = a_ext & b_ext;
                of_nxt  = 1'b0;
            end
            OP_OR: begin
                acc_nxt = a_ext | b_ext;
                of_nxt  = 1'b0;
            end
            OP_XOR: begin
                acc_nxt = a_ext ^ b_ext;
                of_nxt  = 1'b0;
            end
            OP_INV: begin
                acc_nxt = ~a_ext;
                of_nxt  = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/aeolus_mc_cpu.sv
// Aeolus multi-cycle accumulator CPU: IDLE/FETCH/EXEC sequencer, PC, IR and
// architectural registers. Instructions arrive over a variable-latency req/ack port.
module aeolus_mc_cpu
    import aeolus_pkg::*;
#(
    parameter int IN_W   = 4,
    parameter int OUT_W  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [2*IN_W-1:0] switches,
    aeolus_mc_cpu_if.master   imem,
    output logic [OUT_W-1:0]  cpu_out,
    output logic              out_valid,
    output logic              of_flag,
    output logic              sf_flag,
    output logic              busy,
    output logic              pc_wrap
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [3:0]        ir_q, ir_d;
    logic [IN_W-1:0]   a_q, a_d;
    logic [IN_W-1:0]   b_q, b_d;
    logic [OUT_W-1:0]  sr_q, sr_d;
    logic [OUT_W-1:0]  acc_q, acc_d;
    logic [OUT_W-1:0]  o_q, o_d;
    logic              of_q, of_d;
    logic              sf_q, sf_d;
    logic              out_valid_q, out_valid_d;
    logic              pc_wrap_q, pc_wrap_d;

    logic [OUT_W-1:0]  acc_x;
    logic              of_x;
    logic [OUT_W-1:0]  sr_x;
    logic              sf_x;

    aeolus_mc_exec #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_exec (
        .opcode  (ir_q),
        .a       (a_q),
        .b       (b_q),
        .acc     (acc_q),
        .sr      (sr_q),
        .of      (of_q),
        .sf      (sf_q),
        .acc_nxt (acc_x),
        .of_nxt  (of_x),
        .sr_nxt  (sr_x),
        .sf_nxt  (sf_x)
    );

    // Request is decoded from state, so it drops together with an asynchronous reset.
    assign imem.imem_req  = (state_q == ST_FETCH);
    assign imem.imem_addr = pc_q;
    assign busy           = (state_q != ST_IDLE);
    assign cpu_out        = o_q;
    assign out_valid      = out_valid_q;
    assign of_flag        = of_q;
    assign sf_flag        = sf_q;
    assign pc_wrap        = pc_wrap_q;

    // Sequencer and register next-state; ack only matters while fetching.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        sr_d        = sr_q;
        acc_d       = acc_q;
        o_d         = o_q;
        of_d        = of_q;
        sf_d        = sf_q;
        out_valid_d = 1'b0;
        pc_wrap_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem.imem_ack) begin
                    ir_d    = imem.imem_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                acc_d = acc_x;
                of_d  = of_x;
                sr_d  = sr_x;
                sf_d  = sf_x;
                if (ir_q == OP_LDA) a_d = switches[2*IN_W-1:IN_W];
                if (ir_q == OP_LDB) b_d = switches[IN_W-1:0];
                if (ir_q == OP_LDO) begin
                    o_d         = acc_q;
                    out_valid_d = 1'b1;
                end
                pc_d      = pc_q + 1'b1;
                pc_wrap_d = &pc_q;
                state_d   = run ? ST_FETCH : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and register update with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sr_q        <= '0;
            acc_q       <= '0;
            o_q         <= '0;
            of_q        <= 1'b0;
            sf_q        <= 1'b0;
            out_valid_q <= 1'b0;
            pc_wrap_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sr_q        <= sr_d;
            acc_q       <= acc_d;
            o_q         <= o_d;
            of_q        <= of_d;
            sf_q        <= sf_d;
            out_valid_q <= out_valid_d;
            pc_wrap_q   <= pc_wrap_d;
        end
    end

endmodule
